// File: rtl/register_file_param_if.sv
// Bus bundle for register_file_param: read/write request side and registered read response.
interface register_file_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  READ;
  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] ADDR_R1;
  logic [ADDR_WIDTH-1:0] ADDR_R2;
  logic [ADDR_WIDTH-1:0] ADDR_W;
  logic [DATA_WIDTH-1:0] DATA_W;
  logic [DATA_WIDTH-1:0] DATA_R1;
  logic [DATA_WIDTH-1:0] DATA_R2;
  logic                  RVALID;

  modport master (
    output READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
    input  DATA_R1, DATA_R2, RVALID
  );

  modport slave (
    input  READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
    output DATA_R1, DATA_R2, RVALID
  );
endinterface

// File: rtl/register_file_param.sv
// 2-read/1-write register file with registered reads and a one-cycle RVALID.
// Define REGFILE_BYPASS_EN for write-through on same-cycle read/write collisions.
module register_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input logic                  CLK,
  input logic                  RST,
  register_file_param_if.slave bus
);
  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int NUM_RP = 2;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]  r_mem;
  logic [NUM_RP-1:0][ADDR_WIDTH-1:0] w_raddr;
  logic                              r_rvalid;
  logic                              w_rd;
  logic                              w_wr;
  logic                              w_wr_en;

  // X/Z on a request line must never start an operation
  assign w_rd    = (bus.READ  === 1'b1);
  assign w_wr    = (bus.WRITE === 1'b1);
  assign w_wr_en = w_wr && !(ZERO_REG && (bus.ADDR_W == '0));

  assign w_raddr[0] = bus.ADDR_R1;
  assign w_raddr[1] = bus.ADDR_R2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_mem    <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_wr_en) r_mem[bus.ADDR_W] <= bus.DATA_W;
    end
  end

  generate
    for (genvar p = 0; p < NUM_RP; p++) begin : g_rp
      logic [DATA_WIDTH-1:0] w_rdata;
      logic [DATA_WIDTH-1:0] r_rdata;

      // Zero-register masking applied last so it also wins over bypass
      always_comb begin
        w_rdata = r_mem[w_raddr[p]];
`ifdef REGFILE_BYPASS_EN
        if (w_wr && (w_raddr[p] == bus.ADDR_W)) w_rdata = bus.DATA_W;
`endif
        if (ZERO_REG && (w_raddr[p] == '0)) w_rdata = '0;
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST)      r_rdata <= '0;
        else if (w_rd) r_rdata <= w_rdata;
      end
    end
  endgenerate

  assign bus.DATA_R1 = g_rp[0].r_rdata;
  assign bus.DATA_R2 = g_rp[1].r_rdata;
  assign bus.RVALID  = r_rvalid;
endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: three instances (32x32 zero-reg, 32x32 plain, 8x16).
module tb_register_file_param;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  register_file_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) b0 ();
  register_file_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) b1 ();
  register_file_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) b2 ();

  register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) u0 (.CLK(CLK), .RST(RST), .bus(b0.slave));
  register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0)) u1 (.CLK(CLK), .RST(RST), .bus(b1.slave));
  register_file_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b1)) u2 (.CLK(CLK), .RST(RST), .bus(b2.slave));

  typedef logic [31:0] mem32_t [32];
  typedef logic [15:0] mem16_t [8];
  typedef struct { logic [31:0] d1; logic [31:0] d2; } exp_t;

  int vecs = 0;
  int errs = 0;
  mem32_t m0, m1;
  mem16_t m2;
  exp_t q0[$], q1[$], q2[$];
  logic [31:0] h0_1, h0_2, h1_1, h1_2;
  logic [15:0] h2_1, h2_2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl32(input mem32_t m, input bit zr, input logic [4:0] a,
                                        input logic wr, input logic [4:0] aw, input logic [31:0] dw);
    if (zr && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr && a == aw) return dw;
`endif
    return m[a];
  endfunction

  function automatic logic [15:0] mdl16(input mem16_t m, input logic [2:0] a,
                                        input logic wr, input logic [2:0] aw, input logic [15:0] dw);
    if (a == 3'd0) return 16'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr && a == aw) return dw;
`endif
    return m[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin m0[i] = '0; m1[i] = '0; end
    for (int i = 0; i < 8; i++) m2[i] = '0;
    q0.delete(); q1.delete(); q2.delete();
    h0_1 = '0; h0_2 = '0; h1_1 = '0; h1_2 = '0; h2_1 = '0; h2_2 = '0;
  endtask

  task automatic idle();
    b0.READ = 1'b0; b0.WRITE = 1'b0; b0.ADDR_R1 = '0; b0.ADDR_R2 = '0; b0.ADDR_W = '0; b0.DATA_W = '0;
    b1.READ = 1'b0; b1.WRITE = 1'b0; b1.ADDR_R1 = '0; b1.ADDR_R2 = '0; b1.ADDR_W = '0; b1.DATA_W = '0;
    b2.READ = 1'b0; b2.WRITE = 1'b0; b2.ADDR_R1 = '0; b2.ADDR_R2 = '0; b2.ADDR_W = '0; b2.DATA_W = '0;
  endtask

  // One cycle on u0 and u1 with identical stimulus; called at a falling edge
  task automatic step32(input logic rd, input logic [4:0] a1, input logic [4:0] a2,
                        input logic wr, input logic [4:0] aw, input logic [31:0] dw);
    exp_t e;
    b0.READ = rd; b0.ADDR_R1 = a1; b0.ADDR_R2 = a2; b0.WRITE = wr; b0.ADDR_W = aw; b0.DATA_W = dw;
    b1.READ = rd; b1.ADDR_R1 = a1; b1.ADDR_R2 = a2; b1.WRITE = wr; b1.ADDR_W = aw; b1.DATA_W = dw;
    if (rd) begin
      e.d1 = mdl32(m0, 1'b1, a1, wr, aw, dw); e.d2 = mdl32(m0, 1'b1, a2, wr, aw, dw); q0.push_back(e);
      e.d1 = mdl32(m1, 1'b0, a1, wr, aw, dw); e.d2 = mdl32(m1, 1'b0, a2, wr, aw, dw); q1.push_back(e);
    end
    if (wr) begin
      if (aw != 5'd0) m0[aw] = dw;
      m1[aw] = dw;
    end
    @(posedge CLK); #1;
    if (rd) begin
      e = q0.pop_front(); h0_1 = e.d1; h0_2 = e.d2;
      e = q1.pop_front(); h1_1 = e.d1; h1_2 = e.d2;
    end
    chk("u0_rvalid", {31'b0, b0.RVALID}, {31'b0, rd});
    chk("u0_r1", b0.DATA_R1, h0_1);
    chk("u0_r2", b0.DATA_R2, h0_2);
    chk("u1_rvalid", {31'b0, b1.RVALID}, {31'b0, rd});
    chk("u1_r1", b1.DATA_R1, h1_1);
    chk("u1_r2", b1.DATA_R2, h1_2);
    @(negedge CLK);
    idle();
  endtask

  task automatic step16(input logic rd, input logic [2:0] a1, input logic [2:0] a2,
                        input logic wr, input logic [2:0] aw, input logic [15:0] dw);
    exp_t e;
    b2.READ = rd; b2.ADDR_R1 = a1; b2.ADDR_R2 = a2; b2.WRITE = wr; b2.ADDR_W = aw; b2.DATA_W = dw;
    if (rd) begin
      e.d1 = {16'h0, mdl16(m2, a1, wr, aw, dw)};
      e.d2 = {16'h0, mdl16(m2, a2, wr, aw, dw)};
      q2.push_back(e);
    end
    if (wr && aw != 3'd0) m2[aw] = dw;
    @(posedge CLK); #1;
    if (rd) begin
      e = q2.pop_front(); h2_1 = e.d1[15:0]; h2_2 = e.d2[15:0];
    end
    chk("u2_rvalid", {31'b0, b2.RVALID}, {31'b0, rd});
    chk("u2_r1", {16'h0, b2.DATA_R1}, {16'h0, h2_1});
    chk("u2_r2", {16'h0, b2.DATA_R2}, {16'h0, h2_2});
    @(negedge CLK);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    idle();
    RST = 1'b0;
    // Requests during reset must be ignored, including this write
    b0.READ = 1'b1; b1.READ = 1'b1; b2.READ = 1'b1;
    b0.WRITE = 1'b1; b0.ADDR_W = 5'd5; b0.DATA_W = 32'hFFFF_FFFF;
    b1.WRITE = 1'b1; b1.ADDR_W = 5'd5; b1.DATA_W = 32'hFFFF_FFFF;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_u0_rvalid", {31'b0, b0.RVALID}, 32'h0);
    chk("rst_u0_r1", b0.DATA_R1, 32'h0);
    chk("rst_u1_r2", b1.DATA_R2, 32'h0);
    chk("rst_u2_rvalid", {31'b0, b2.RVALID}, 32'h0);
    @(negedge CLK);
    idle();
    RST = 1'b1;
    step32(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    step16(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 32; i++) step32(1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0);
    chk("rst_read5_u1", b1.DATA_R1, 32'h0);

    // Write then read
    step32(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    step32(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0);
    chk("wr_rd_r1", b0.DATA_R1, 32'hDEAD_BEEF);
    chk("wr_rd_r2", b0.DATA_R2, 32'hDEAD_BEEF);
    chk("wr_rd_rvalid", {31'b0, b0.RVALID}, 32'h1);

    // Collision on register 7
    step32(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h1111_1111);
    step32(1'b1, 5'd7, 5'd5, 1'b1, 5'd7, 32'h2222_2222);
`ifdef REGFILE_BYPASS_EN
    chk("collide_r1", b0.DATA_R1, 32'h2222_2222);
`else
    chk("collide_r1", b0.DATA_R1, 32'h1111_1111);
`endif
    step32(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0);
    chk("collide_after", b0.DATA_R1, 32'h2222_2222);

    // Zero register vs ordinary register 0
    step32(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step32(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("zero_u0", b0.DATA_R1, 32'h0);
    chk("zero_u1", b1.DATA_R1, 32'hFFFF_FFFF);
    step32(1'b1, 5'd0, 5'd5, 1'b1, 5'd0, 32'h1234_5678);
    chk("zero_bypass_u0", b0.DATA_R1, 32'h0);

    // Hold with READ=0
    step32(1'b0, 5'd3, 5'd4, 1'b0, 5'd0, 32'h0);
    chk("hold_r2", b0.DATA_R2, 32'hDEAD_BEEF);

    // Mixed traffic
    for (int i = 0; i < 40; i++)
      step32(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);

    // Asynchronous reset between edges with a read pending
    step32(1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 32'hA5A5_A5A5);
    step32(1'b1, 5'd31, 5'd31, 1'b0, 5'd0, 32'h0);
    chk("pre_rst_r1", b0.DATA_R1, 32'hA5A5_A5A5);
    b0.READ = 1'b1; b0.ADDR_R1 = 5'd31;
    b1.READ = 1'b1; b1.ADDR_R1 = 5'd31;
    #2 RST = 1'b0;
    #1;
    chk("midrst_r1", b0.DATA_R1, 32'h0);
    chk("midrst_rvalid", {31'b0, b0.RVALID}, 32'h0);
    chk("midrst_u1_r1", b1.DATA_R1, 32'h0);
    clear_model();
    @(negedge CLK);
    idle();
    RST = 1'b1;
    step32(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    step32(1'b1, 5'd31, 5'd31, 1'b0, 5'd0, 32'h0);
    chk("postrst_r31", b0.DATA_R1, 32'h0);

    // Narrow instance
    step16(1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 16'hBEEF);
    step16(1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 16'h1234);
    step16(1'b1, 3'd7, 3'd3, 1'b0, 3'd0, 16'h0);
    chk("p16_r1", {16'h0, b2.DATA_R1}, 32'h0000_BEEF);
    chk("p16_r2", {16'h0, b2.DATA_R2}, 32'h0000_1234);
    step16(1'b0, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
    chk("p16_hold_r1", {16'h0, b2.DATA_R1}, 32'h0000_BEEF);
    chk("p16_hold_rvalid", {31'b0, b2.RVALID}, 32'h0);
    step16(1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF);
    step16(1'b1, 3'd0, 3'd7, 1'b1, 3'd7, 16'h5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: register and data-port width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: address width; depth = 2**ADDR_WIDTH registers.
REQ-003 SHALL have parameter ZERO_REG, default 1: 1 = register 0 reads as zero and ignores writes; 0 = register 0 is ordinary.
REQ-004 SHALL have port CLK  input  1  clock; all synchronous activity on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port READ  input  1  read request; samples ADDR_R1/ADDR_R2.
REQ-007 SHALL have port WRITE  input  1  write request; samples ADDR_W/DATA_W.
REQ-008 SHALL have port ADDR_R1  input  ADDR_WIDTH  read port 1 address.
REQ-009 SHALL have port ADDR_R2  input  ADDR_WIDTH  read port 2 address.
REQ-010 SHALL have port ADDR_W  input  ADDR_WIDTH  write address.
REQ-011 SHALL have port DATA_W  input  DATA_WIDTH  write data.
REQ-012 SHALL have port DATA_R1  output  DATA_WIDTH  registered read data, port 1.
REQ-013 SHALL have port DATA_R2  output  DATA_WIDTH  registered read data, port 2.
REQ-014 SHALL have port RVALID  output  1  high for exactly the cycle after an accepted read.

Function
REQ-015 SHALL accept READ and WRITE in the same cycle; both operations complete (no mutual exclusion, no X outputs).
REQ-016 SHALL, on rising CLK with READ=1, load DATA_R1/DATA_R2 from ADDR_R1/ADDR_R2; read latency exactly 1 cycle.
REQ-017 SHALL set RVALID=1 on the edge where READ=1 was sampled, and RVALID=0 on the edge where READ=0 was sampled.
REQ-018 SHALL hold DATA_R1/DATA_R2 unchanged when READ=0.
REQ-019 SHALL, on rising CLK with WRITE=1, store DATA_W into register ADDR_W; new value visible to reads sampled on subsequent edges.
REQ-020 SHALL, when ZERO_REG=1, discard writes to address 0 and return all-zero for any read of address 0, including under bypass.
REQ-021 SHALL treat READ or WRITE at X/Z as 0 (no operation).
REQ-022 SHALL allow ADDR_R1 = ADDR_R2; both ports return identical data.
REQ-023 SHALL make same-cycle read/write address collision behaviour depend solely on REGFILE_BYPASS_EN (REQ-027/028).

Reset
REQ-024 SHALL, while RST=0, asynchronously clear all 2**ADDR_WIDTH registers, DATA_R1, DATA_R2 and RVALID to 0.
REQ-025 SHALL ignore READ and WRITE on any edge while RST=0; a write coinciding with reset assertion is lost.
REQ-026 SHALL resume normal operation on the first rising CLK after RST returns to 1.

Configuration
REQ-027 SHALL, with macro REGFILE_BYPASS_EN defined, return DATA_W on a read port whose address equals ADDR_W in a cycle where READ=1 and WRITE=1 (write-through).
REQ-028 SHALL, without REGFILE_BYPASS_EN, return the pre-write register contents in that collision case (read-before-write).

Verification
REQ-029 Bench SHALL check reset: after RST pulse, READ all 32 addresses -> DATA_R1=DATA_R2=0x00000000, RVALID=0 during and 1 cycle after reset.
REQ-030 Bench SHALL check write/read: WRITE addr 5 = 0xDEADBEEF, next cycle READ R1=5,R2=5 -> one cycle later DATA_R1=DATA_R2=0xDEADBEEF, RVALID=1.
REQ-031 Bench SHALL check collision: reg 7 = 0x11111111, then same cycle WRITE 7 = 0x22222222 with READ R1=7 -> DATA_R1=0x22222222 with REGFILE_BYPASS_EN, 0x11111111 without; next read 0x22222222 both builds.
REQ-032 Bench SHALL check zero register: ZERO_REG=1, WRITE addr 0 = 0xFFFFFFFF, READ R1=0 -> 0x00000000; ZERO_REG=0 -> 0xFFFFFFFF.
REQ-033 Bench SHALL check mid-operation reset: write 0xA5A5A5A5 to addr 31, assert RST asynchronously between edges with READ=1 -> DATA_R1=0 and RVALID=0 immediately; after release READ 31 -> 0x00000000.
REQ-034 Bench SHALL check parametrisation: DATA_WIDTH=16, ADDR_WIDTH=3, write 0xBEEF to addr 7 then 0x1234 to addr 3, READ R1=7,R2=3 -> DATA_R1=0xBEEF, DATA_R2=0x1234; READ=0 next cycle -> outputs hold, RVALID=0.
